// File: rtl/ddr_image_loader.sv
// Multi-region DDR preload engine: optional config word then NUM_REGION base/length
// images, each stream word split into LSB-first narrow writes with backpressure.
module ddr_image_loader #(
  parameter int                    PORT_DATAWIDTH = 128,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    NUM_REGION     = 4,
  parameter int                    LEN_WIDTH      = 20,
  parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSET    = 32'h0800_0000,
  localparam int                   IW             = (NUM_REGION > 1) ? $clog2(NUM_REGION) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             cfg_en,
  input  logic [ADDR_WIDTH-1:0]            cfg_addr,
  input  logic [PORT_DATAWIDTH-1:0]        cfg_word,
  input  logic [NUM_REGION*ADDR_WIDTH-1:0] region_base,
  input  logic [NUM_REGION*LEN_WIDTH-1:0]  region_len,
  input  logic [PORT_DATAWIDTH-1:0]        s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_ready,
  output logic                             busy,
  output logic                             done,
  output logic [IW-1:0]                    region_idx
);

  localparam int LANES = PORT_DATAWIDTH / DATA_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LANES_A = ADDR_WIDTH'(LANES);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_SEL, S_FETCH, S_WRITE, S_DONE} state_t;
  state_t state_q, state_d;

  logic                                   cfg_en_q;
  logic [ADDR_WIDTH-1:0]                  cfg_addr_q;
  logic [PORT_DATAWIDTH-1:0]              cfg_word_q;
  logic [NUM_REGION-1:0][ADDR_WIDTH-1:0]  base_q;
  logic [NUM_REGION-1:0][LEN_WIDTH-1:0]   len_q;
  logic [PORT_DATAWIDTH-1:0]              hold_q;
  logic [LW-1:0]                          lane_q;
  logic [LEN_WIDTH-1:0]                   word_q;
  logic [IW:0]                            scan_q;   // one extra bit so "past last region" is representable
  logic [IW-1:0]                          region_q;

  logic                                   found;
  logic [IW-1:0]                          found_k;
  logic                                   last_lane, word_last;
  logic [LANES-1:0][DATA_WIDTH-1:0]       lane_w;
  logic [ADDR_WIDTH-1:0]                  base_idx;

  // Lowest non-empty region at or above the scan pointer
  always_comb begin
    found   = 1'b0;
    found_k = '0;
    for (int k = NUM_REGION - 1; k >= 0; k--) begin
      if ((IW+1)'(k) >= scan_q && len_q[k] != '0) begin
        found   = 1'b1;
        found_k = IW'(k);
      end
    end
  end

  assign last_lane = (lane_q == LW'(LANES - 1));
  assign word_last = ((word_q + LEN_WIDTH'(1)) == len_q[region_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    mem_we  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = cfg_en ? S_CFG : S_SEL;
      end
      S_CFG: begin
        mem_we = 1'b1;
        if (mem_ready && last_lane) state_d = S_SEL;
      end
      S_SEL:   state_d = found ? S_FETCH : S_DONE;
      S_FETCH: begin
        s_ready = 1'b1;
        if (s_valid) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (mem_ready && last_lane) state_d = word_last ? S_SEL : S_FETCH;
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_en_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_word_q <= '0;
      base_q     <= '0;
      len_q      <= '0;
      hold_q     <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      scan_q     <= '0;
      region_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          cfg_en_q   <= cfg_en;
          cfg_addr_q <= cfg_addr;
          cfg_word_q <= cfg_word;
          base_q     <= region_base;
          len_q      <= region_len;
          lane_q     <= '0;
          word_q     <= '0;
          scan_q     <= '0;
        end
        S_CFG: if (mem_ready) lane_q <= last_lane ? '0 : lane_q + LW'(1);
        S_SEL: if (found) begin
          region_q <= found_k;
          word_q   <= '0;
        end
        S_FETCH: if (s_valid) begin
          hold_q <= s_data;
          lane_q <= '0;
        end
        S_WRITE: if (mem_ready) begin
          lane_q <= last_lane ? '0 : lane_q + LW'(1);
          if (last_lane) begin
            word_q <= word_q + LEN_WIDTH'(1);
            if (word_last) scan_q <= {1'b0, region_q} + (IW+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign lane_w   = (state_q == S_CFG) ? cfg_word_q : hold_q;
  assign base_idx = (state_q == S_CFG) ? (cfg_addr_q - ADDR_OFFSET)
                  : (base_q[region_q] - ADDR_OFFSET + ADDR_WIDTH'(word_q) * LANES_A);

  // Address/data forced to zero when no write is presented
  assign mem_addr   = mem_we ? base_idx + ADDR_WIDTH'(lane_q) : '0;
  assign mem_wdata  = mem_we ? lane_w[lane_q] : '0;
  assign region_idx = region_q;

  // cfg_en is consumed at start; the latched copy is kept for visibility only
  logic unused_cfg_en;
  assign unused_cfg_en = cfg_en_q;

endmodule

// File: tb/tb_ddr_image_loader.sv
// Scoreboard bench for ddr_image_loader: a loop-based model queues expected writes,
// a negedge monitor pops and compares every accepted write.
module tb_ddr_image_loader;
  localparam int PW = 128, DW = 8, AW = 32, NR = 4, LNW = 20, LANES = PW / DW;
  localparam logic [AW-1:0] OFF = 32'h0800_0000;

  logic             clk, rst_n, start, cfg_en, s_valid, s_ready, mem_we, mem_ready, busy, done;
  logic [AW-1:0]    cfg_addr, mem_addr;
  logic [PW-1:0]    cfg_word, s_data;
  logic [NR*AW-1:0] region_base;
  logic [NR*LNW-1:0] region_len;
  logic [DW-1:0]    mem_wdata;
  logic [1:0]       region_idx;

  ddr_image_loader #(.PORT_DATAWIDTH(PW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGION(NR),
                     .LEN_WIDTH(LNW), .ADDR_OFFSET(OFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_en(cfg_en), .cfg_addr(cfg_addr),
    .cfg_word(cfg_word), .region_base(region_base), .region_len(region_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
    .done(done), .region_idx(region_idx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int region; } exp_t;
  exp_t          exp_q[$];
  logic [PW-1:0] stream_q[$];
  logic [PW-1:0] wbuf[$];

  int errors = 0, checks = 0;
  int wr_cnt = 0, done_cnt = 0, acc_cnt = 0, sready_cnt = 0;
  int ready_mode = 0;
  bit gap_en = 0, pend = 0, stall_prev = 0, tog = 0, first_seen = 0;
  logic [AW-1:0] prev_addr, first_addr;
  logic [DW-1:0] prev_data;

  // model configuration
  bit            m_cfg_en;
  logic [AW-1:0] m_cfg_addr;
  logic [PW-1:0] m_cfg_word;
  logic [AW-1:0] m_base[NR];
  int            m_len[NR];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endfunction

  // Monitor + stream/ready driver, all on the negedge
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0; stall_prev = 0;
    end else begin
      if (pend) begin void'(stream_q.pop_front()); pend = 0; end
      case (ready_mode)
        0:       mem_ready = 1'b1;
        1:       begin tog = !tog; mem_ready = tog; end
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      s_valid = (stream_q.size() > 0) && (!gap_en || $urandom_range(0, 2) != 0);
      s_data  = (stream_q.size() > 0) ? stream_q[0] : '0;
      if (s_valid && s_ready) begin pend = 1; acc_cnt++; end
      if (s_ready) sready_cnt++;
      if (stall_prev && mem_we) begin
        chk("stall_addr", 64'(mem_addr), 64'(prev_addr));
        chk("stall_data", 64'(mem_wdata), 64'(prev_data));
      end
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.addr));
          chk("wr_data", 64'(mem_wdata), 64'(e.data));
          if (e.region >= 0) chk("region_idx", 64'(region_idx), 64'(e.region));
        end
        if (!first_seen) begin first_addr = mem_addr; first_seen = 1; end
        wr_cnt++;
      end
      stall_prev = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
      if (done) begin
        done_cnt++;
        chk("done_after_last_write", 64'(exp_q.size()), 64'd0);
        chk("busy_low_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic gen_words(input int n);
    wbuf.delete();
    for (int i = 0; i < n; i++) wbuf.push_back({$urandom, $urandom, $urandom, $urandom});
  endtask

  // Reference: list every write the configuration implies, in order
  task automatic build();
    exp_t x;
    int wi = 0;
    exp_q.delete(); stream_q.delete();
    if (m_cfg_en)
      for (int i = 0; i < LANES; i++) begin
        x.addr = m_cfg_addr - OFF + AW'(i); x.data = m_cfg_word[i*DW +: DW]; x.region = -1;
        exp_q.push_back(x);
      end
    for (int k = 0; k < NR; k++)
      for (int w = 0; w < m_len[k]; w++) begin
        logic [PW-1:0] word = wbuf[wi++];
        stream_q.push_back(word);
        for (int i = 0; i < LANES; i++) begin
          x.addr = m_base[k] - OFF + AW'(w * LANES + i); x.data = word[i*DW +: DW]; x.region = k;
          exp_q.push_back(x);
        end
      end
  endtask

  task automatic apply();
    cfg_en = m_cfg_en; cfg_addr = m_cfg_addr; cfg_word = m_cfg_word;
    for (int k = 0; k < NR; k++) begin
      region_base[k*AW +: AW]   = m_base[k];
      region_len[k*LNW +: LNW]  = LNW'(m_len[k]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run(input bit poke);
    int d0, cyc, nw;
    nw = 0;
    for (int k = 0; k < NR; k++) nw += m_len[k];
    build(); apply();
    acc_cnt = 0; sready_cnt = 0; first_seen = 0; d0 = done_cnt;
    pulse_start();
    if (poke) begin
      repeat (3) @(negedge clk);
      chk("busy_when_restarted", 64'(busy), 64'd1);
      cfg_en = 1'b1; region_base = '1; region_len = '1; cfg_addr = '0;
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin @(negedge clk); cyc++; end
    if (done_cnt == d0) begin
      errors++; checks++;
      $display("FAIL done_timeout: no done after %0d cycles, want done", cyc);
    end
    chk("stream_words", 64'(acc_cnt), 64'(nw));
    if (!gap_en) chk("s_ready_cycles", 64'(sready_cnt), 64'(nw));
    repeat (2) @(negedge clk);
  endtask

  task automatic set_plain(input logic [AW-1:0] b0, input int l0);
    m_cfg_en = 0; m_cfg_addr = '0; m_cfg_word = '0;
    for (int k = 0; k < NR; k++) begin m_base[k] = OFF + AW'(k) * 32'h0010_0000; m_len[k] = 0; end
    m_base[0] = b0; m_len[0] = l0;
  endtask

  initial begin
    int cyc;
    rst_n = 0; start = 0; cfg_en = 0; cfg_addr = '0; cfg_word = '0; region_base = '0;
    region_len = '0; s_valid = 0; s_data = '0; mem_ready = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_s_ready", 64'(s_ready), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_region_idx", 64'(region_idx), 64'd0);

    // 1: config only
    set_plain(32'h0810_0000, 0);
    m_cfg_en = 1; m_cfg_addr = 32'h0800_0100;
    for (int i = 0; i < LANES; i++) m_cfg_word[i*DW +: DW] = DW'(i);
    run(0);

    // 2: single region, two words
    set_plain(32'h0810_0000, 2); gen_words(2);
    run(0);

    // 3: same with alternating backpressure
    ready_mode = 1; run(0); ready_mode = 0;

    // 4: region skip {3,0,1,0}
    set_plain(32'h0810_0000, 3); m_len[2] = 1; m_base[2] = 32'h0830_0040; gen_words(4);
    run(0);

    // 5: reset during lane 4 of word 1, then full restart
    set_plain(32'h0810_0000, 2); gen_words(2);
    build(); apply();
    cyc = wr_cnt;
    pulse_start();
    while (wr_cnt - cyc < LANES + 4 && wr_cnt - cyc < 5000) begin @(posedge clk); #2; end
    chk("pre_reset_lane_addr", 64'(mem_addr), 64'h0010_0014);
    rst_n = 0; #1;
    chk("mid_reset_mem_we", 64'(mem_we), 64'd0);
    chk("mid_reset_busy", 64'(busy), 64'd0);
    chk("mid_reset_s_ready", 64'(s_ready), 64'd0);
    repeat (2) @(negedge clk);
    exp_q.delete(); stream_q.delete();
    #1 rst_n = 1;
    run(0);

    // 6: start while busy is ignored, then base below the offset wraps
    set_plain(32'h0810_0000, 2); gen_words(2);
    run(1);
    set_plain(32'h0000_0010, 1); gen_words(1);
    run(0);
    chk("wrap_first_index", 64'(first_addr), 64'hF800_0010);

    // randomized configurations with random backpressure and stream gaps
    for (int t = 0; t < 6; t++) begin
      int tot = 0;
      m_cfg_en = 1'($urandom_range(0, 1));
      m_cfg_addr = OFF + AW'($urandom_range(0, 32'hFFFF));
      m_cfg_word = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < NR; k++) begin
        m_base[k] = (t == 5 && k == 1) ? AW'($urandom) : OFF + AW'($urandom_range(0, 32'hFFFFF));
        m_len[k]  = $urandom_range(0, 3);
        tot += m_len[k];
      end
      gen_words(tot);
      ready_mode = 2; gap_en = 1'($urandom_range(0, 1));
      run(0);
    end
    ready_mode = 0; gap_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddr_image_loader.md
Name: ddr_image_loader

Overview:
- Synthesizable multi-region DDR preload engine. Latches one optional configuration word plus NUM_REGION base/length pairs, then consumes a stream of PORT_DATAWIDTH-bit words.
- Splits each word into LANES = PORT_DATAWIDTH/DATA_WIDTH narrow writes on a byte-addressed memory port with backpressure.
- Sits between the host/FPGA data source and the DDR model/controller. Loads the CFG, ACT, FLGACT, WEI and FLGWEI images ahead of layer execution.

Parameters:
- PORT_DATAWIDTH, 128, stream word width; must be an integer multiple of DATA_WIDTH.
- DATA_WIDTH, 8, memory-port write width.
- ADDR_WIDTH, 32, address width.
- NUM_REGION, 4, number of image regions.
- LEN_WIDTH, 20, width of the per-region word count.
- ADDR_OFFSET, 32'h0800_0000, subtracted from every base address to form the memory index.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse; ignored unless idle
- cfg_en  in  1  1 = emit the config word before the regions
- cfg_addr  in  ADDR_WIDTH  config word base address
- cfg_word  in  PORT_DATAWIDTH  config word
- region_base  in  NUM_REGION*ADDR_WIDTH  region k base at [k*ADDR_WIDTH +: ADDR_WIDTH]
- region_len  in  NUM_REGION*LEN_WIDTH  region k length in stream words; 0 = skip
- s_data  in  PORT_DATAWIDTH  stream word
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- mem_we  out  1  write request
- mem_addr  out  ADDR_WIDTH  write index
- mem_wdata  out  DATA_WIDTH  write data
- mem_ready  in  1  write accepted when mem_we && mem_ready
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- region_idx  out  clog2(NUM_REGION)  region currently loading

Behaviour:
- Reset: all outputs 0; state IDLE; counters, holding register and latched config cleared. Reset mid-operation discards any partial word; no further writes are issued.
- start in IDLE latches cfg_en, cfg_addr, cfg_word, region_base and region_len. Inputs may change afterwards without effect. start while busy is ignored.
- States:
  - IDLE -> CFG if cfg_en, else SEL.
  - CFG: emits LANES writes of the latched cfg_word, then -> SEL.
  - SEL: picks the lowest region k >= current index with len != 0. Sets region_idx = k, word_cnt = 0, then -> FETCH. If no such region remains -> DONE. SEL takes one cycle per evaluation; zero-length regions are skipped with no writes.
  - FETCH: s_ready = 1. On s_valid, the word is captured into the holding register -> WRITE.
  - WRITE: emits LANES writes. After the last lane: word_cnt++. If word_cnt == len, advance the region and go to SEL; otherwise go to FETCH.
  - DONE: done = 1 for one cycle, busy drops -> IDLE.
- s_ready is high only in FETCH. The first lane write is presented the cycle after the word is accepted.
- Lane order is LSB first: lane i = word[i*DATA_WIDTH +: DATA_WIDTH].
- Addressing:
  - Config: mem_addr = cfg_addr - ADDR_OFFSET + i.
  - Region: mem_addr = base_k - ADDR_OFFSET + word_cnt*LANES + i.
  - All arithmetic is modulo 2^ADDR_WIDTH; a base below ADDR_OFFSET wraps.
- Handshake:
  - While mem_we && !mem_ready, mem_addr and mem_wdata are held stable and the lane counter does not advance.
  - mem_we stays high across consecutive lanes when mem_ready = 1, giving one write per cycle.
- Throughput with no stalls: LANES + 1 cycles per word (one FETCH cycle plus LANES write cycles).

Test Plan:
1. Config only. cfg_en=1, cfg_addr=0x0800_0100, cfg_word=0x...0F0E..0100 (byte i = i), all lengths 0, mem_ready=1. Expect 16 writes at indices 0x100..0x10F with data 0x00..0x0F, then a done pulse; s_ready never asserts.
2. Single region. cfg_en=0, region0 base=0x0810_0000, len=2, words W0 then W1. Expect 32 writes at 0x0010_0000..0x0010_001F, LSB lane first. s_ready is high exactly twice, each time for 1 cycle when s_valid is held at 1.
3. Backpressure. Same as scenario 2 with mem_ready toggling 1010... Expect the same 32 writes in the same order, mem_addr/mem_wdata stable during every stall, and no dropped or duplicated lanes.
4. Region skip. Lengths {3,0,1,0}. Expect region_idx to show 0 then 2, 64 writes in total, region 2 writes starting at base2-ADDR_OFFSET, and done after the last write.
5. Reset mid-load. Assert rst_n=0 during the 5th lane of word 1. Expect mem_we, busy and s_ready to go to 0 immediately. A restart reproduces the full sequence from scenario 2 exactly.
6. Ignored start and wrap. Pulse start while busy: no relatch, and the sequence is unchanged. Then use base=0x0000_0010: the first index is 0xF800_0010.
